// File: rtl/tohost_exit_monitor.sv
// Purpose : turns tohost writes into the harness pass/fail/exit-code outputs, drains console chars, watchdog.
// Latency : exit/putchar beat accepted at edge N -> registered outputs valid after edge N.
// Backpr. : io_wr_ready drops while a console character waits for io_putc_ready; otherwise always ready.
//
// Ports:
//   clk, reset                 sole clock (rising edge), asynchronous active-high reset
//   io_wr_valid/ready/addr/data/mask   memory-side write beat stream observed from the DUT
//   io_putc_valid/ready/data   console character handshake towards the console sink
//   io_success, io_failure     sticky completion flags (mutually exclusive)
//   io_exit_code               exit code latched together with the first completion flag
module tohost_exit_monitor #(
    parameter int unsigned            ADDR_W      = 32,
    parameter logic [ADDR_W-1:0]      TOHOST_ADDR = 32'h8000_1000,
    parameter int unsigned            STALL_LIMIT = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_wr_valid,
    output logic              io_wr_ready,
    input  logic [ADDR_W-1:0] io_wr_addr,
    input  logic [63:0]       io_wr_data,
    input  logic [7:0]        io_wr_mask,
    output logic              io_putc_valid,
    input  logic              io_putc_ready,
    output logic [7:0]        io_putc_data,
    output logic              io_success,
    output logic              io_failure,
    output logic [46:0]       io_exit_code
);

    localparam logic [31:0] LP_LIMIT        = 32'(STALL_LIMIT);
    localparam logic [46:0] LP_CODE_UNKNOWN = 47'h7FFF_FFFF_FFFF;
    localparam logic [46:0] LP_CODE_STALL   = 47'h7FFF_FFFF_FFFE;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PUTC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_success;
    logic        r_failure;
    logic [46:0] r_exit_code;
    logic        r_putc_vld;
    logic [7:0]  r_putc_data;
    logic [31:0] r_wdog;

    state_t      w_nx_state;
    logic        w_nx_success;
    logic        w_nx_failure;
    logic [46:0] w_nx_exit_code;
    logic        w_nx_putc_vld;
    logic [7:0]  w_nx_putc_data;
    logic [31:0] w_nx_wdog;

    logic        w_accept;
    logic        w_match;
    logic [7:0]  w_dev;
    logic [7:0]  w_cmd;
    logic [46:0] w_code;

    // Ready is purely a function of state so it reads 1 while reset is held.
    assign io_wr_ready = (r_state != ST_PUTC);
    assign w_accept    = io_wr_valid && io_wr_ready;
    assign w_match     = w_accept && (io_wr_addr == TOHOST_ADDR) && (io_wr_mask == 8'hFF);
    assign w_dev       = io_wr_data[63:56];
    assign w_cmd       = io_wr_data[55:48];
    assign w_code      = io_wr_data[47:1];

    always_comb begin
        w_nx_state     = r_state;
        w_nx_success   = r_success;
        w_nx_failure   = r_failure;
        w_nx_exit_code = r_exit_code;
        w_nx_putc_vld  = r_putc_vld;
        w_nx_putc_data = r_putc_data;
        w_nx_wdog      = r_wdog;

        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    // Any beat, matching or not, counts as forward progress and
                    // takes priority over a watchdog expiry in the same cycle.
                    w_nx_wdog = '0;
                    // An all-zero tohost write is the target clearing the mailbox.
                    if (w_match && (io_wr_data != 64'd0)) begin
                        if ((w_dev == 8'd0) && io_wr_data[0]) begin
                            w_nx_exit_code = w_code;
                            w_nx_success   = (w_code == '0);
                            w_nx_failure   = (w_code != '0);
                            w_nx_state     = ST_DONE;
                        end else if ((w_dev == 8'd1) && (w_cmd == 8'd1)) begin
                            w_nx_putc_vld  = 1'b1;
                            w_nx_putc_data = io_wr_data[7:0];
                            w_nx_state     = ST_PUTC;
                        end else begin
                            w_nx_failure   = 1'b1;
                            w_nx_exit_code = LP_CODE_UNKNOWN;
                            w_nx_state     = ST_DONE;
                        end
                    end
                end else if (STALL_LIMIT != 0) begin
                    // Failure is raised on the same edge the count reaches the limit.
                    w_nx_wdog = r_wdog + 32'd1;
                    if (w_nx_wdog == LP_LIMIT) begin
                        w_nx_failure   = 1'b1;
                        w_nx_exit_code = LP_CODE_STALL;
                        w_nx_state     = ST_DONE;
                    end
                end
            end
            ST_PUTC: begin
                if (io_putc_ready) begin
                    w_nx_putc_vld = 1'b0;
                    w_nx_state    = ST_IDLE;
                end
            end
            ST_DONE: begin
                // Terminal: beats are swallowed, flags and code stay frozen.
            end
            default: begin
                w_nx_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_success   <= 1'b0;
            r_failure   <= 1'b0;
            r_exit_code <= '0;
            r_putc_vld  <= 1'b0;
            r_putc_data <= '0;
            r_wdog      <= '0;
        end else begin
            r_state     <= w_nx_state;
            r_success   <= w_nx_success;
            r_failure   <= w_nx_failure;
            r_exit_code <= w_nx_exit_code;
            r_putc_vld  <= w_nx_putc_vld;
            r_putc_data <= w_nx_putc_data;
            r_wdog      <= w_nx_wdog;
        end
    end

    assign io_putc_valid = r_putc_vld;
    assign io_putc_data  = r_putc_data;
    assign io_success    = r_success;
    assign io_failure    = r_failure;
    assign io_exit_code  = r_exit_code;

endmodule

// File: tb/tb_tohost_exit_monitor.sv
// Purpose : randomized + directed bench for tohost_exit_monitor against a behavioural model.
// Latency : outputs compared at the falling edge after each rising edge.
// Backpr. : io_putc_ready driven randomly or held low to exercise PUTC stalls.
module tb_tohost_exit_monitor;

    localparam logic [31:0] TOHOST = 32'h8000_1000;
    localparam int unsigned LIMIT  = 10;

    logic        clk;
    logic        reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_addr;
    logic [63:0] wr_data;
    logic [7:0]  wr_mask;
    logic        putc_valid;
    logic        putc_ready;
    logic [7:0]  putc_data;
    logic        success;
    logic        failure;
    logic [46:0] exit_code;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model of what the harness should report.
    bit              m_char_pending;
    bit              m_finished;
    bit              m_pass;
    bit              m_fail;
    logic [7:0]      m_char;
    longint unsigned m_code;
    int unsigned     m_idle;

    tohost_exit_monitor #(
        .ADDR_W      (32),
        .TOHOST_ADDR (TOHOST),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .io_wr_valid   (wr_valid),
        .io_wr_ready   (wr_ready),
        .io_wr_addr    (wr_addr),
        .io_wr_data    (wr_data),
        .io_wr_mask    (wr_mask),
        .io_putc_valid (putc_valid),
        .io_putc_ready (putc_ready),
        .io_putc_data  (putc_data),
        .io_success    (success),
        .io_failure    (failure),
        .io_exit_code  (exit_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 = clear mailbox, 1 = exit, 2 = putchar, 3 = unknown command
    function automatic int classify(input logic [63:0] d);
        longint unsigned v;
        v = d;
        if (v == 0) return 0;
        if ((v >> 56) == 0 && (v % 2) == 1) return 1;
        if ((v >> 56) == 1 && ((v >> 48) % 256) == 1) return 2;
        return 3;
    endfunction

    task automatic model_reset();
        m_char_pending = 0;
        m_finished     = 0;
        m_pass         = 0;
        m_fail         = 0;
        m_char         = 8'h00;
        m_code         = 0;
        m_idle         = 0;
    endtask

    task automatic finish_with(input bit pass, input longint unsigned code);
        m_pass     = pass;
        m_fail     = !pass;
        m_code     = code;
        m_finished = 1;
    endtask

    // Applies one rising edge's worth of harness behaviour to the model.
    task automatic model_edge();
        bit acc;
        acc = wr_valid && !m_char_pending;
        if (m_char_pending) begin
            if (putc_ready) m_char_pending = 0;
        end else if (!m_finished) begin
            if (acc) begin
                m_idle = 0;
                if (wr_addr == TOHOST && wr_mask == 8'hFF) begin
                    case (classify(wr_data))
                        1: finish_with(wr_data[47:1] == 0, longint'(wr_data[47:1]));
                        2: begin
                            m_char_pending = 1;
                            m_char         = wr_data[7:0];
                        end
                        3: finish_with(0, 64'h7FFF_FFFF_FFFF);
                        default: ;
                    endcase
                end
            end else begin
                m_idle++;
                if (m_idle >= LIMIT) finish_with(0, 64'h7FFF_FFFF_FFFE);
            end
        end
    endtask

    task automatic compare_all();
        check_eq("wr_ready", 64'(wr_ready), 64'(!m_char_pending));
        check_eq("putc_valid", 64'(putc_valid), 64'(m_char_pending));
        if (m_char_pending) check_eq("putc_data", 64'(putc_data), 64'(m_char));
        check_eq("success", 64'(success), 64'(m_pass));
        check_eq("failure", 64'(failure), 64'(m_fail));
        check_eq("exit_code", 64'(exit_code), m_code);
        check_eq("flags_exclusive", 64'(success & failure), 64'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic beat(input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
    endtask

    task automatic idle();
        wr_valid = 1'b0;
    endtask

    task automatic idle_steps(input int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    // Asserts reset between clock edges and checks outputs clear without a clock.
    task automatic do_reset();
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        compare_all();
        idle();
        putc_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        wr_valid   = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        wr_mask    = '0;
        putc_ready = 1'b1;
        model_reset();
        #3;
        compare_all();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Pass exit
        beat(TOHOST, 64'h1, 8'hFF); step(); idle();
        check_eq("pass_success", 64'(success), 64'd1);
        check_eq("pass_code", 64'(exit_code), 64'd0);
        step();

        // Fail exit is sticky against a later pass write
        do_reset();
        beat(TOHOST, 64'h7, 8'hFF); step();
        check_eq("fail7_failure", 64'(failure), 64'd1);
        check_eq("fail7_code", 64'(exit_code), 64'd3);
        beat(TOHOST, 64'h1, 8'hFF); step(); idle();
        check_eq("sticky_success", 64'(success), 64'd0);
        check_eq("sticky_code", 64'(exit_code), 64'd3);

        // Putchar held off by the console sink while another beat is offered
        do_reset();
        putc_ready = 1'b0;
        beat(TOHOST, 64'h0101_0000_0000_0041, 8'hFF); step();
        beat(TOHOST, 64'h1, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("putc_hold_valid", 64'(putc_valid), 64'd1);
            check_eq("putc_hold_data", 64'(putc_data), 64'h41);
            check_eq("putc_hold_ready", 64'(wr_ready), 64'd0);
        end
        idle(); putc_ready = 1'b1; step();
        check_eq("putc_done_valid", 64'(putc_valid), 64'd0);
        check_eq("putc_done_ready", 64'(wr_ready), 64'd1);
        // Back-to-back characters: one every two cycles
        beat(TOHOST, 64'h0101_0000_0000_0042, 8'hFF);
        for (int i = 0; i < 6; i++) step();

        // Non-matching beats, then unknown command
        do_reset();
        beat(TOHOST + 32'd8, 64'h1, 8'hFF); step();
        beat(TOHOST, 64'h1, 8'h0F); step(); idle();
        check_eq("nomatch_success", 64'(success), 64'd0);
        check_eq("nomatch_failure", 64'(failure), 64'd0);
        beat(TOHOST, 64'h0200_0000_0000_0000, 8'hFF); step(); idle();
        check_eq("unknown_failure", 64'(failure), 64'd1);
        check_eq("unknown_code", 64'(exit_code), 64'h7FFF_FFFF_FFFF);

        // Watchdog straight out of reset
        do_reset();
        idle_steps(LIMIT - 1);
        check_eq("wd_early", 64'(failure), 64'd0);
        idle_steps(1);
        check_eq("wd_reset_expiry", 64'(failure), 64'd1);

        // Non-matching beat at idle cycle 9, then silence
        do_reset();
        idle_steps(8);
        beat(TOHOST + 32'd8, 64'h1, 8'hFF); step();
        idle_steps(LIMIT - 1);
        check_eq("wd_before", 64'(failure), 64'd0);
        idle_steps(1);
        check_eq("wd_after", 64'(failure), 64'd1);
        check_eq("wd_code", 64'(exit_code), 64'h7FFF_FFFF_FFFE);

        // A beat landing exactly on the expiry cycle wins
        do_reset();
        idle_steps(LIMIT - 1);
        beat(TOHOST, 64'h0, 8'hFF); step(); idle();
        check_eq("wd_beat_wins", 64'(failure), 64'd0);
        idle_steps(3);

        // Reset after success, then pass again
        do_reset();
        beat(TOHOST, 64'h1, 8'hFF); step(); idle();
        do_reset();
        check_eq("rst_after_pass", 64'(success), 64'd0);
        beat(TOHOST, 64'h1, 8'hFF); step(); idle();
        check_eq("repass", 64'(success), 64'd1);

        // Reset in the middle of a stalled putchar
        do_reset();
        putc_ready = 1'b0;
        beat(TOHOST, 64'h0101_0000_0000_0055, 8'hFF); step(); idle(); step();
        do_reset();
        check_eq("rst_mid_putc", 64'(putc_valid), 64'd0);
        beat(TOHOST, 64'h1, 8'hFF); step(); idle();
        check_eq("pass_after_putc_rst", 64'(success), 64'd1);

        // Randomized episodes
        for (int ep = 0; ep < 25; ep++) begin
            int busy;
            do_reset();
            busy = (ep % 4 == 3) ? 15 : 80;
            for (int s = 0; s < 40; s++) begin
                int pick;
                logic [63:0] d;
                logic [31:0] a;
                logic [7:0]  m;
                pick = $urandom_range(0, 99);
                if (pick < 10)      d = 64'h0;
                else if (pick < 13) d = 64'h1;
                else if (pick < 17) d = (64'($urandom_range(1, 40)) << 1) | 64'h1;
                else if (pick < 70) d = {16'h0101, 40'h0, 8'($urandom)};
                else if (pick < 80) d = 64'h2;
                else                d = {$urandom, $urandom};
                a = ($urandom_range(0, 9) < 7) ? TOHOST :
                    (($urandom_range(0, 1) == 1) ? TOHOST + 32'd8 : $urandom);
                m = ($urandom_range(0, 9) < 8) ? 8'hFF : 8'($urandom);
                if ($urandom_range(0, 99) < busy) beat(a, d, m);
                else idle();
                putc_ready = ($urandom_range(0, 2) != 0);
                step();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
